// File: rtl/rs232_rx.sv
// 8N1 UART receiver: 2-flop synchronizer, oversampling FSM, one-cycle valid/frame_err strobes.
// Latency: strobe 3+HALF+9*DIV cycles after pin fall (+1 with RS232_RX_MAJORITY_EN); no backpressure, missed strobes lose the byte.
// Optional RS232_RX_MAJORITY_EN: 2-of-3 vote around every sample point.
module rs232_rx #(
   parameter int CLK_FREQ = 50_000_000,
   parameter int BAUD     = 115200
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       rx,
   output logic [7:0] data,
   output logic       valid,
   output logic       frame_err
);

   localparam int DIV  = CLK_FREQ / BAUD;
   localparam int HALF = DIV / 2;

   localparam logic [15:0] BIT_END = 16'(DIV - 1);
`ifdef RS232_RX_MAJORITY_EN
   // Start check ends one cycle later so every later window is target-1..target+1.
   localparam logic [15:0] START_END = 16'(HALF);
`else
   localparam logic [15:0] START_END = 16'(HALF - 1);
`endif

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      STOP,
      WAIT_HIGH
   } state_t;

   state_t      state, state_nxt;
   logic [15:0] cnt, cnt_nxt;
   logic [2:0]  bitidx, bitidx_nxt;
   logic [7:0]  shreg, shreg_nxt;
   logic [7:0]  data_nxt;
   logic        valid_nxt, ferr_nxt;
   logic        rx_m, rx_s;
   logic        smp;

   always_ff @(posedge clk) begin
      if (rst) begin
         rx_m <= 1'b1;
         rx_s <= 1'b1;
      end else begin
         rx_m <= rx;
         rx_s <= rx_m;
      end
   end

`ifdef RS232_RX_MAJORITY_EN
   logic [1:0] hist;

   always_ff @(posedge clk) begin
      if (rst) begin
         hist <= 2'b11;
      end else begin
         hist <= {hist[0], rx_s};
      end
   end

   assign smp = (hist[1] & hist[0]) | (hist[1] & rx_s) | (hist[0] & rx_s);
`else
   assign smp = rx_s;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         cnt       <= 16'd0;
         bitidx    <= 3'd0;
         shreg     <= 8'h00;
         data      <= 8'h00;
         valid     <= 1'b0;
         frame_err <= 1'b0;
      end else begin
         state     <= state_nxt;
         cnt       <= cnt_nxt;
         bitidx    <= bitidx_nxt;
         shreg     <= shreg_nxt;
         data      <= data_nxt;
         valid     <= valid_nxt;
         frame_err <= ferr_nxt;
      end
   end

   always_comb begin
      state_nxt  = state;
      cnt_nxt    = cnt;
      bitidx_nxt = bitidx;
      shreg_nxt  = shreg;
      data_nxt   = data;
      valid_nxt  = 1'b0;
      ferr_nxt   = 1'b0;

      case (state)
         IDLE: begin
            cnt_nxt = 16'd0;
            if (!rx_s) begin
               state_nxt = START;
            end
         end

         START: begin
            if (cnt == START_END) begin
               cnt_nxt    = 16'd0;
               bitidx_nxt = 3'd0;
               // A line back high at mid-start is a glitch, not a frame.
               state_nxt  = smp ? IDLE : DATA;
            end else begin
               cnt_nxt = cnt + 16'd1;
            end
         end

         DATA: begin
            if (cnt == BIT_END) begin
               shreg_nxt[bitidx] = smp;
               cnt_nxt           = 16'd0;
               bitidx_nxt        = bitidx + 3'd1;
               if (bitidx == 3'd7) begin
                  state_nxt = STOP;
               end
            end else begin
               cnt_nxt = cnt + 16'd1;
            end
         end

         STOP: begin
            if (cnt == BIT_END) begin
               cnt_nxt = 16'd0;
               if (smp) begin
                  // Leaving at mid-stop lets a back-to-back start bit be seen.
                  data_nxt  = shreg;
                  valid_nxt = 1'b1;
                  state_nxt = IDLE;
               end else begin
                  ferr_nxt  = 1'b1;
                  state_nxt = WAIT_HIGH;
               end
            end else begin
               cnt_nxt = cnt + 16'd1;
            end
         end

         WAIT_HIGH: begin
            cnt_nxt = 16'd0;
            if (rx_s) begin
               state_nxt = IDLE;
            end
         end

         default: begin
            state_nxt = IDLE;
            cnt_nxt   = 16'd0;
         end
      endcase
   end

endmodule

// File: tb/tb_rs232_rx.sv
// Bench for rs232_rx: directed and randomized 8N1 frames scored against an expectation list.
module tb_rs232_rx;

   localparam int CLK_FREQ = 50_000_000;
   localparam int BAUD     = 115200;
   localparam int DIV      = CLK_FREQ / BAUD;
   localparam int HALF     = DIV / 2;
`ifdef RS232_RX_MAJORITY_EN
   localparam int MAJ = 1;
`else
   localparam int MAJ = 0;
`endif
   localparam int LAT = 2 + HALF + 9 * DIV + 1 + MAJ;
   localparam int TOL = 2;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       rx  = 1'b1;
   logic [7:0] data;
   logic       valid;
   logic       frame_err;

   always #10 clk = ~clk;

   rs232_rx #(
      .CLK_FREQ(CLK_FREQ),
      .BAUD    (BAUD)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .rx       (rx),
      .data     (data),
      .valid    (valid),
      .frame_err(frame_err)
   );

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   logic rst_q = 1'b1;
   always @(posedge clk) rst_q <= rst;

   int         checks   = 0;
   int         failures = 0;
   int         exp_kind   [64];
   logic [7:0] exp_byte   [64];
   int         exp_due    [64];
   int         strobe_cyc [64];
   int         n_exp = 0;
   int         n_got = 0;
   logic [7:0] model_data = 8'h00;

   task automatic chk(input string name, input int act, input int req);
      checks++;
      if (act != req) begin
         failures++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   task automatic chk_range(input string name, input int act, input int lo, input int hi);
      checks++;
      if (act < lo || act > hi) begin
         failures++;
         $display("FAIL %s: got %0d, expected %0d..%0d (cycle %0d)", name, act, lo, hi, cyc);
      end
   endtask

   task automatic hold(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Drives one frame; kind 1 = good byte expected, 2 = framing error expected.
   task automatic send(input logic [7:0] b, input int period, input logic stop_lvl, input int extra_low);
      rx = 1'b0;
      exp_kind[n_exp] = stop_lvl ? 1 : 2;
      exp_byte[n_exp] = b;
      exp_due[n_exp]  = cyc + LAT;
      n_exp++;
      hold(period);
      for (int k = 0; k < 8; k++) begin
         rx = b[k];
         hold(period);
      end
      rx = stop_lvl;
      hold(period + extra_low);
      rx = 1'b1;
   endtask

   task automatic compare_loop();
      forever begin
         @(negedge clk);
         if (cyc > 99000) begin
            $display("FAIL watchdog: cycle %0d exceeded budget 99000", cyc);
            $fatal(1, "watchdog expired");
         end
         if (rst_q) begin
            model_data = 8'h00;
         end else begin
            if (valid && frame_err) begin
               chk("strobe_exclusive", 1, 0);
            end
            if (valid || frame_err) begin
               if (n_got >= n_exp) begin
                  checks++;
                  failures++;
                  $display("FAIL spurious_strobe: got valid=%0b frame_err=%0b data=0x%0h, expected no strobe (cycle %0d)",
                           valid, frame_err, data, cyc);
               end else begin
                  chk("strobe_kind", valid ? 1 : 2, exp_kind[n_got]);
                  chk_range("strobe_time", cyc, exp_due[n_got] - TOL, exp_due[n_got] + TOL);
                  if (exp_kind[n_got] == 1) begin
                     chk("valid_data", int'(data), int'(exp_byte[n_got]));
                     model_data = exp_byte[n_got];
                  end
                  strobe_cyc[n_got] = cyc;
                  n_got++;
               end
            end else if (n_got < n_exp && cyc > exp_due[n_got] + TOL) begin
               checks++;
               failures++;
               $display("FAIL missing_strobe: got nothing by cycle %0d, expected kind %0d near cycle %0d",
                        cyc, exp_kind[n_got], exp_due[n_got]);
               n_got++;
            end
            chk("data_hold", int'(data), int'(model_data));
         end
      end
   endtask

   initial begin
      int         first_fall;
      logic [7:0] rb;
      int         rp;
      logic       rs;
      int         re;

      fork
         compare_loop();
      join_none

      hold(5);
      chk("reset_data", int'(data), 0);
      chk("reset_valid", int'(valid), 0);
      chk("reset_frame_err", int'(frame_err), 0);
      rst = 1'b0;
      hold(50);

      // 0xFF at 8700 ns per bit
      first_fall = cyc;
      send(8'hFF, 435, 1'b1, 0);
      hold(20);
      chk("ff_data", int'(data), 8'hFF);
      chk_range("ff_latency", strobe_cyc[0] - first_fall, 4126 + MAJ - TOL, 4126 + MAJ + TOL);

      // back-to-back frames
      send(8'h55, 435, 1'b1, 0);
      send(8'hA3, 435, 1'b1, 0);
      hold(20);
      chk("b2b_data", int'(data), 8'hA3);

      // 100 ns glitch, then a frame that only decodes if the FSM is idle again
      rx = 1'b0;
      hold(5);
      rx = 1'b1;
      hold(220);

      send(8'h3C, 435, 1'b0, 1000);
      hold(100);
      chk("ferr_data_kept", int'(data), 8'hA3);
      send(8'h81, 435, 1'b1, 0);
      hold(20);
      chk("after_ferr_data", int'(data), 8'h81);

      // reset during bit 4 of 0x0F; no expectation is recorded for it
      rb = 8'h0F;
      rx = 1'b0;
      hold(435);
      for (int k = 0; k < 4; k++) begin
         rx = rb[k];
         hold(435);
      end
      rx = rb[4];
      hold(200);
      rst = 1'b1;
      hold(1);
      rst = 1'b0;
      rx  = 1'b1;
      hold(1000);
      chk("midframe_reset_data", int'(data), 0);
      send(8'hC6, 435, 1'b1, 0);
      hold(20);
      chk("after_reset_data", int'(data), 8'hC6);

      // +/-3% bit period
      send(8'h5A, 421, 1'b1, 0);
      hold(30);
      chk("skew_fast_data", int'(data), 8'h5A);
      send(8'h5A, 447, 1'b1, 0);
      hold(30);
      chk("skew_slow_data", int'(data), 8'h5A);

      for (int i = 0; i < 6; i++) begin
         rb = 8'($urandom_range(0, 255));
         rp = int'($urandom_range(425, 443));
         rs = ($urandom_range(0, 4) != 0);
         re = rs ? 0 : int'($urandom_range(0, 300));
         send(rb, rp, rs, re);
         hold(rs ? int'($urandom_range(0, 40)) : int'($urandom_range(3, 40)));
      end

      hold(200);
      chk("all_frames_seen", n_got, n_exp);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/rs232_rx.md
# rs232_rx

UART receiver for the RS232 link: oversamples the asynchronous serial line with the system clock and recovers 8N1 frames (1 start, 8 data LSB first, 1 stop). It sits directly downstream of the serial `rx` pin, or of the behavioural transmitter in benches, and hands each byte to the fabric as a one-cycle strobe. Framing errors are flagged rather than delivered as data.

## Interface
- `CLK_FREQ`, 50_000_000: system clock frequency in Hz.
- `BAUD`, 115200: line rate in bit/s.
- Derived constants: `DIV = CLK_FREQ/BAUD` (integer division, 434 at defaults) and `HALF = DIV/2` (217 at defaults).
- `clk  in  1`: single system clock. All logic runs on the rising edge.
- `rst  in  1`: synchronous, active-high reset.
- `rx  in  1`: asynchronous serial line. Idle level is 1.
- `data  out  8`: last correctly received byte. Held until the next good frame.
- `valid  out  1`: one-cycle strobe when `data` updates.
- `frame_err  out  1`: one-cycle strobe when the stop bit samples 0.

## Operation
- The line passes through a 2-flop synchronizer (`rx_s`). The synchronizer flops reset to 1.
- The FSM has five states: IDLE, START, DATA, STOP, WAIT_HIGH. A bit counter `cnt` is 16 bits wide, which covers `DIV` up to 65535.
- **IDLE**: if `rx_s==0`, go to START with `cnt=0`.
- **START**: increment `cnt`. At `cnt==HALF-1`, sample `rx_s`:
  - sample is 0: go to DATA, `cnt=0`, `bitidx=0`.
  - sample is 1: treat as a glitch and return to IDLE. No output.
- **DATA**: at `cnt==DIV-1`, sample `rx_s` into `shreg[bitidx]` (LSB first), then increment `bitidx` and clear `cnt`. After bit 7, go to STOP.
- **STOP**: at `cnt==DIV-1`, sample the stop bit:
  - sample is 1: `data<=shreg`, pulse `valid`, go to IDLE. Entry happens at mid-stop, so a back-to-back start bit is caught.
  - sample is 0: pulse `frame_err`, leave `data` unchanged, go to WAIT_HIGH.
- **WAIT_HIGH**: stay until `rx_s==1`, then go to IDLE. This state absorbs break conditions and emits no further strobes.
- `valid` and `frame_err` are mutually exclusive and never assert on consecutive frames without a full frame in between.
- The receiver has no input handshake. A consumer that misses the strobe loses the byte. There is no overrun flag.

## Timing
- Reset values: `data=8'h00`, `valid=0`, `frame_err=0`, state IDLE, `cnt=0`, `shreg=0`.
- Reset mid-frame: the partial frame is discarded with no strobe. The block returns to IDLE on the next edge.
- Sampling points after the falling edge, counted from when `rx_s` shows the falling edge:
  - start-bit check at `HALF` cycles;
  - data bit k at `HALF+(k+1)*DIV` cycles;
  - stop bit at `HALF+9*DIV` cycles.
- Latency: `valid`/`frame_err` rises 2+HALF+9*DIV+1 cycles after the pin's falling edge. That is 4126 cycles at defaults. Benches accept ±2 cycles for synchronizer phase.
- `rx` is sampled on every clock edge. No combinational path runs from `rx` to any output.
- Baud tolerance: frames with bit period within ±3% of `DIV` decode correctly. A frame at 8700 ns per bit on a 20 ns clock is 435 cycles and must decode.

## Configuration
- `RS232_RX_MAJORITY_EN` defined: every sample (start, data, stop) is a 2-of-3 majority of `rx_s` at `cnt` = target-1, target, target+1. The decision registers at target+1, so the strobe latency grows by 1 cycle. A single-cycle spike at the sample point is rejected.
- `RS232_RX_MAJORITY_EN` undefined: single sample at target, with the latency stated above.

## Test plan
- **Single 0xFF frame**: reset, then line idle 1000 ns, start 8700 ns, data high 69600 ns, stop. Required: `valid` pulses once with `data==8'hFF` about 82.5 µs after the falling edge, and `frame_err` stays 0.
- **Byte 0x55 then 0xA3 back-to-back**: the second start bit begins immediately after the first stop bit. Required: two `valid` pulses with `data` 0x55 then 0xA3, no `frame_err`.
- **Glitch**: a 100 ns low pulse on an idle line. Required: no strobes, FSM back in IDLE before 4.4 µs.
- **Framing error**: 0x3C with the stop bit forced to 0, line held low 20 µs, then a valid 0x81. Required: one `frame_err` pulse, `data` stays at its previous value, then `valid` with 0x81.
- **Reset mid-frame**: assert `rst` one cycle during bit 4 of 0x0F, then send 0xC6. Required: no strobe for the aborted frame, `valid` with 0xC6.
- **Baud skew**: send 0x5A at bit periods of 421 and 447 cycles (±3%). Required: `valid` with 0x5A in both cases.
